cruise_speed_ctrl: RTL and testbench
====================================

Name: cruise_speed_ctrl

Overview:
- Sequencing controller that drives the cruise-control ALU and consumes its outputs.
- Owns the target (default) and current speed registers and selects the ALU mode each cycle.
- Latches the ALU result on speed-update ticks.
- Sits between driver pedal/button inputs and the combinational ALU; it is the ALU's sole master.

Parameters:
- TICK_DIV, 4, clock cycles per speed-update tick (>=1)
- MAX_SPEED, 200, saturation ceiling for current_speed
- MIN_CRUISE, 40, minimum current_speed at which cruise may engage

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- engine_on  in  1  level; 0 forces OFF
- accel  in  1  level; accelerator pressed
- brake  in  1  level; brake pressed
- cruise_set  in  1  single-cycle pulse; engage cruise at current speed
- alu_result  in  8  ALU result (combinational from the outputs below)
- alu_g  in  1  ALU flag: current_speed > default_speed
- alu_eq  in  1  ALU flag: current_speed == default_speed
- alu_l  in  1  ALU flag: current_speed < default_speed
- default_speed  out  8  registered target speed, to ALU
- current_speed  out  8  registered current speed, to ALU
- mode  out  2  ALU operation select, combinational from state/inputs/flags
- cruise_active  out  1  registered; 1 in CRUISE and OVERRIDE
- state_o  out  2  registered FSM state, for debug

Behaviour:
- Reset (async, rst_n=0): state OFF, default_speed=0, current_speed=0, cruise_active=0, tick counter=0. mode=0 while in OFF.
- ALU mode encoding (package):
  - 0 HOLD: result=current_speed
  - 1 INC: current_speed+1, saturating at 255
  - 2 DEC: current_speed-1, saturating at 0
  - 3 LOAD: result=default_speed
- Combinational loop rule: mode may depend on alu_g/eq/l, because the flags depend only on the speed registers. mode must never depend on alu_result.
- Tick counter:
  - Runs 0..TICK_DIV-1 when state!=OFF and wraps.
  - tick=1 when count==TICK_DIV-1.
  - Cleared to 0 on entry to OFF.
- current_speed updates only on tick: current_speed <= min(alu_result, MAX_SPEED). Latency from mode selection to new speed is 1 cycle after the tick.
- Input priority in every non-OFF state: !engine_on > brake > cruise_set > accel.
- OFF (0):
  - mode=HOLD.
  - engine_on=1 -> MANUAL next cycle.
- MANUAL (1):
  - mode = DEC if brake; else INC if accel; else HOLD.
  - cruise_set & !brake & current_speed>=MIN_CRUISE -> CRUISE, default_speed<=current_speed, cruise_active<=1.
  - cruise_set below MIN_CRUISE is ignored.
- CRUISE (2):
  - mode = DEC if alu_g, INC if alu_l, HOLD if alu_eq.
  - Result: current_speed converges to the target by 1 per tick.
  - brake -> MANUAL, cruise_active<=0, default_speed retained.
  - accel -> OVERRIDE.
  - cruise_set -> default_speed<=current_speed; stays in CRUISE.
- OVERRIDE (3):
  - mode=INC.
  - accel released -> CRUISE; default_speed is unchanged, so the FSM decelerates back to the old target.
  - brake -> MANUAL, cruise_active<=0.
- engine_on=0 in any state -> OFF next cycle. Clears both speeds and cruise_active. This overrides a simultaneous tick.
- At MAX_SPEED, INC holds current_speed at MAX_SPEED. At 0, DEC holds 0.
- A state transition and a tick in the same cycle: the speed update uses the mode of the pre-transition state.
- Reset mid-operation: immediate return to reset values. There is no resume of the previous target.

Decomposition:
- Package cruise_pkg:
  - ALU mode localparams MODE_HOLD/INC/DEC/LOAD.
  - State encodings ST_OFF/MANUAL/CRUISE/OVERRIDE.
  - Speed width constant SPEED_W=8.
- Sub-module tick_gen (parameter TICK_DIV; ports clk, rst_n, clr, tick) holds the counter.
- FSM, speed registers and mode decode stay in cruise_speed_ctrl.
- Bench instantiates the real ALU for closed-loop tests.

Test Plan:
1. Reset then engine_on=1, accel=1 for 40 cycles (TICK_DIV=4) -> current_speed=10, state MANUAL, mode=1 while accel held.
2. Ramp to 60, pulse cruise_set -> default_speed=60, cruise_active=1. Release accel and idle 40 cycles -> current_speed stays 60, mode=0.
3. In CRUISE at 60, accel=1 for 20 cycles (speed 65), then release -> state CRUISE. Speed decreases 65->60 at 1 per tick, then mode=0.
4. Brake and cruise_set asserted in the same cycle while in CRUISE -> MANUAL, cruise_active=0, default_speed=60 retained, mode=2.
5. cruise_set at current_speed=30 -> ignored, state stays MANUAL. Hold accel to 200 -> saturates at 200. Hold brake to 0 -> stays at 0.
6. engine_on=0 for one cycle while in CRUISE; separately, rst_n=0 mid-tick -> OFF, both speeds 0, cruise_active 0. The async reset takes effect without waiting for a clock edge.

Source files
------------

// File: rtl/cruise_pkg.sv
// Shared encodings for the cruise-control sequencer and the ALU it drives.
package cruise_pkg;

    localparam int SPEED_W = 8;

    localparam logic [1:0] MODE_HOLD = 2'd0;
    localparam logic [1:0] MODE_INC  = 2'd1;
    localparam logic [1:0] MODE_DEC  = 2'd2;
    localparam logic [1:0] MODE_LOAD = 2'd3;

    localparam logic [1:0] ST_OFF      = 2'd0;
    localparam logic [1:0] ST_MANUAL   = 2'd1;
    localparam logic [1:0] ST_CRUISE   = 2'd2;
    localparam logic [1:0] ST_OVERRIDE = 2'd3;

endpackage

// File: rtl/cruise_speed_ctrl_tick_gen.sv
// Speed-update tick divider: one-cycle tick every TICK_DIV cycles while not cleared.
module tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr || count_reg == LAST) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // Gated so a cleared counter never produces a stray tick when TICK_DIV is 1.
    assign tick = !clr && (count_reg == LAST);

endmodule

// File: rtl/cruise_speed_ctrl.sv
// Cruise-control sequencer: owns the speed registers and is the sole master of the speed ALU.
import cruise_pkg::*;

module cruise_speed_ctrl #(
    parameter int TICK_DIV   = 4,
    parameter int MAX_SPEED  = 200,
    parameter int MIN_CRUISE = 40
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               engine_on,
    input  logic               accel,
    input  logic               brake,
    input  logic               cruise_set,
    input  logic [SPEED_W-1:0] alu_result,
    input  logic               alu_g,
    input  logic               alu_eq,
    input  logic               alu_l,
    output logic [SPEED_W-1:0] default_speed,
    output logic [SPEED_W-1:0] current_speed,
    output logic [1:0]         mode,
    output logic               cruise_active,
    output logic [1:0]         state_o
);

    localparam logic [SPEED_W-1:0] MAX_SPEED_V  = SPEED_W'(MAX_SPEED);
    localparam logic [SPEED_W-1:0] MIN_CRUISE_V = SPEED_W'(MIN_CRUISE);

    logic [1:0]         state_reg, state_next;
    logic [SPEED_W-1:0] default_speed_reg, default_speed_next;
    logic [SPEED_W-1:0] current_speed_reg, current_speed_next;
    logic               cruise_active_reg, cruise_active_next;
    logic               tick;
    logic               tick_clr;

    // Holding the counter clear on engine-off keeps it at zero from the first OFF cycle.
    assign tick_clr = (state_reg == ST_OFF) || !engine_on;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tick_clr),
        .tick  (tick)
    );

    // Mode depends on flags only, never on alu_result, to avoid a combinational loop.
    always_comb begin
        mode = MODE_HOLD;
        case (state_reg)
            ST_MANUAL:   mode = brake ? MODE_DEC : (accel ? MODE_INC : MODE_HOLD);
            ST_CRUISE:   mode = alu_g ? MODE_DEC : (alu_l ? MODE_INC : MODE_HOLD);
            ST_OVERRIDE: mode = MODE_INC;
            default:     mode = MODE_HOLD;
        endcase
    end

    always_comb begin
        state_next         = state_reg;
        default_speed_next = default_speed_reg;
        current_speed_next = current_speed_reg;
        if (tick) begin
            current_speed_next = (alu_result > MAX_SPEED_V) ? MAX_SPEED_V : alu_result;
        end
        if (!engine_on) begin
            state_next         = ST_OFF;
            default_speed_next = '0;
            current_speed_next = '0;
        end else begin
            case (state_reg)
                ST_OFF: state_next = ST_MANUAL;
                ST_MANUAL: begin
                    if (cruise_set && !brake && current_speed_reg >= MIN_CRUISE_V) begin
                        state_next         = ST_CRUISE;
                        default_speed_next = current_speed_reg;
                    end
                end
                ST_CRUISE: begin
                    if (brake) begin
                        state_next = ST_MANUAL;
                    end else if (cruise_set) begin
                        default_speed_next = current_speed_reg;
                    end else if (accel) begin
                        state_next = ST_OVERRIDE;
                    end
                end
                default: begin
                    // A set while overriding re-targets to the overridden speed.
                    if (brake) begin
                        state_next = ST_MANUAL;
                    end else if (cruise_set) begin
                        state_next         = ST_CRUISE;
                        default_speed_next = current_speed_reg;
                    end else if (!accel) begin
                        state_next = ST_CRUISE;
                    end
                end
            endcase
        end
        cruise_active_next = (state_next == ST_CRUISE) || (state_next == ST_OVERRIDE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= ST_OFF;
            default_speed_reg <= '0;
            current_speed_reg <= '0;
            cruise_active_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            default_speed_reg <= default_speed_next;
            current_speed_reg <= current_speed_next;
            cruise_active_reg <= cruise_active_next;
        end
    end

    assign default_speed = default_speed_reg;
    assign current_speed = current_speed_reg;
    assign cruise_active = cruise_active_reg;
    assign state_o       = state_reg;

endmodule

// File: tb/tb_cruise_speed_ctrl.sv
// Closed-loop bench: controller plus behavioural ALU, table vectors, corner sequences and random run.
module tb_cruise_speed_ctrl;

    localparam int TICK_DIV   = 4;
    localparam int MAX_SPEED  = 200;
    localparam int MIN_CRUISE = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       engine_on = 1'b0;
    logic       accel = 1'b0;
    logic       brake = 1'b0;
    logic       cruise_set = 1'b0;
    logic [7:0] alu_result;
    logic       alu_g, alu_eq, alu_l;
    logic [7:0] default_speed, current_speed;
    logic [1:0] mode;
    logic       cruise_active;
    logic [1:0] state_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cruise_speed_ctrl #(
        .TICK_DIV   (TICK_DIV),
        .MAX_SPEED  (MAX_SPEED),
        .MIN_CRUISE (MIN_CRUISE)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .engine_on     (engine_on),
        .accel         (accel),
        .brake         (brake),
        .cruise_set    (cruise_set),
        .alu_result    (alu_result),
        .alu_g         (alu_g),
        .alu_eq        (alu_eq),
        .alu_l         (alu_l),
        .default_speed (default_speed),
        .current_speed (current_speed),
        .mode          (mode),
        .cruise_active (cruise_active),
        .state_o       (state_o)
    );

    // Cruise ALU: hold / saturating inc / saturating dec / load target.
    always_comb begin
        case (mode)
            2'd1:    alu_result = (current_speed == 8'hFF) ? 8'hFF : current_speed + 8'd1;
            2'd2:    alu_result = (current_speed == 8'h00) ? 8'h00 : current_speed - 8'd1;
            2'd3:    alu_result = default_speed;
            default: alu_result = current_speed;
        endcase
    end
    assign alu_g  = current_speed >  default_speed;
    assign alu_eq = current_speed == default_speed;
    assign alu_l  = current_speed <  default_speed;

    // Reference model: 0 off, 1 manual, 2 cruise, 3 override; phase counts cycles since last tick.
    int m_state, m_phase, m_cur, m_def, m_act;

    function automatic int exp_mode(logic a, logic b);
        if (m_state == 1) return b ? 2 : (a ? 1 : 0);
        if (m_state == 3) return 1;
        if (m_state == 2) begin
            if (m_cur == m_def) return 0;
            return (m_cur > m_def) ? 2 : 1;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_state = 0; m_phase = 0; m_cur = 0; m_def = 0; m_act = 0;
    endtask

    task automatic model_step(logic e, logic a, logic b, logic c);
        int md;
        int new_cur;
        bit tk;
        md = exp_mode(a, b);
        tk = (m_state != 0) && e && (m_phase == TICK_DIV - 1);
        new_cur = m_cur;
        if (tk) begin
            new_cur = m_cur + ((md == 1) ? 1 : (md == 2) ? -1 : 0);
            if (new_cur > MAX_SPEED) new_cur = MAX_SPEED;
            if (new_cur < 0) new_cur = 0;
        end
        if (!e) begin
            model_reset();
            return;
        end
        m_phase = (m_state == 0) ? 0 : (m_phase + 1) % TICK_DIV;
        case (m_state)
            0: m_state = 1;
            1: if (c && !b && m_cur >= MIN_CRUISE) begin m_def = m_cur; m_state = 2; end
            2: begin
                if (b) m_state = 1;
                else if (c) m_def = m_cur;
                else if (a) m_state = 3;
            end
            default: begin
                if (b) m_state = 1;
                else if (c) begin m_def = m_cur; m_state = 2; end
                else if (!a) m_state = 2;
            end
        endcase
        m_cur = new_cur;
        m_act = (m_state >= 2) ? 1 : 0;
    endtask

    task automatic check(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_regs(string tag);
        check({tag, ".state"}, int'(state_o), m_state);
        check({tag, ".cur"}, int'(current_speed), m_cur);
        check({tag, ".def"}, int'(default_speed), m_def);
        check({tag, ".active"}, int'(cruise_active), m_act);
    endtask

    // Inputs driven just after a rising edge; mode checked 1 time unit later, registers after the edge.
    task automatic do_cycle(logic e, logic a, logic b, logic c);
        engine_on = e; accel = a; brake = b; cruise_set = c;
        #1;
        check("cyc.mode", int'(mode), exp_mode(a, b));
        @(posedge clk);
        model_step(e, a, b, c);
        #1;
        check_regs("cyc");
    endtask

    typedef struct {
        logic e, a, b, c;
        int   n;
        int   st, cur, def, act, md;
    } vec_t;

    vec_t vecs[15];

    initial begin
        //             e     a     b     c     n    st  cur def act md
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0,  41,  1,  10,  0, 0, 1};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 200,  1,  60,  0, 0, 1};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1,   1,  2,  60, 60, 1, 0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0,  40,  2,  60, 60, 1, 0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0,  20,  3,  65, 60, 1, 1};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0,   1,  2,  65, 60, 1, 2};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0,  40,  2,  60, 60, 1, 0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1,   1,  1,  60, 60, 0, 2};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 120,  1,  30, 60, 0, 2};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1,   1,  1,  30, 60, 0, 0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 800,  1, 200, 60, 0, 1};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 900,  1,   0, 60, 0, 2};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 240,  1,  60, 60, 0, 1};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1,   1,  2,  60, 60, 1, 0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0,   1,  0,   0,  0, 0, 0};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst.state", int'(state_o), 0);
        check("rst.cur", int'(current_speed), 0);
        check("rst.def", int'(default_speed), 0);
        check("rst.active", int'(cruise_active), 0);
        check("rst.mode", int'(mode), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            for (int k = 0; k < vecs[i].n; k++)
                do_cycle(vecs[i].e, vecs[i].a, vecs[i].b, vecs[i].c);
            check($sformatf("vec%0d.state", i), int'(state_o), vecs[i].st);
            check($sformatf("vec%0d.cur", i), int'(current_speed), vecs[i].cur);
            check($sformatf("vec%0d.def", i), int'(default_speed), vecs[i].def);
            check($sformatf("vec%0d.active", i), int'(cruise_active), vecs[i].act);
            check($sformatf("vec%0d.mode", i), int'(mode), vecs[i].md);
            $display("[TB] vec %0d: state=%0d cur=%0d def=%0d active=%0d mode=%0d",
                     i, state_o, current_speed, default_speed, cruise_active, mode);
        end

        // Async reset between edges while accelerating in MANUAL.
        for (int k = 0; k < 13; k++) do_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("pre_rst.cur", int'(current_speed), 3);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst.state", int'(state_o), 0);
        check("async_rst.cur", int'(current_speed), 0);
        check("async_rst.def", int'(default_speed), 0);
        check("async_rst.active", int'(cruise_active), 0);
        $display("[TB] async reset: state=%0d cur=%0d def=%0d", state_o, current_speed, default_speed);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Random closed-loop run against the model; engine-off is rare so speeds build up.
        for (int k = 0; k < 4000; k++) begin
            do_cycle(($urandom_range(0, 199) != 0),
                     ($urandom_range(0, 1) == 1),
                     ($urandom_range(0, 11) == 0),
                     ($urandom_range(0, 15) == 0));
        end
        $display("[TB] random run: state=%0d cur=%0d def=%0d", state_o, current_speed, default_speed);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
